// File: rtl/vga_pkg.sv
// vga_pkg: shared pixel-stream types and default geometry
package vga_pkg;
    localparam int default_x_bits   = 3;
    localparam int default_y_bits   = 3;
    localparam int default_pix_bits = 4;
    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DONE} wr_state_t;
endpackage

// File: rtl/raster_pos_counter.sv
// raster_pos_counter: x/y raster position with wrap at the frame bounds
module raster_pos_counter
    import vga_pkg::*;
#(
    parameter int x_bits = default_x_bits,
    parameter int y_bits = default_y_bits
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [x_bits:0]   width,
    input  logic [y_bits:0]   height,
    output logic [x_bits-1:0] x,
    output logic [y_bits-1:0] y,
    output logic              line_end,
    output logic              last
);
    assign line_end = {1'b0, x} == width - (x_bits + 1)'(1);
    assign last     = line_end && ({1'b0, y} == height - (y_bits + 1)'(1));

    // advance one pixel per enable; the last pixel of the frame wraps both axes to 0
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            x <= line_end ? '0 : x + x_bits'(1);
            y <= last ? '0 : (line_end ? y + y_bits'(1) : y);
        end
    end
endmodule

// File: rtl/frame_stream_writer.sv
// frame_stream_writer: raster pixel stream sink writing pixels to frame memory
module frame_stream_writer
    import vga_pkg::*;
#(
    parameter int x_bits   = default_x_bits,
    parameter int y_bits   = default_y_bits,
    parameter int pix_bits = default_pix_bits
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [x_bits:0]          width,
    input  logic [y_bits:0]          height,
    input  logic                     start,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [pix_bits-1:0]      s_data,
    input  logic                     s_sof,
    input  logic                     s_eol,
    output logic                     wr_en,
    output logic [x_bits+y_bits-1:0] wr_addr,
    output logic [pix_bits-1:0]      wr_data,
    output logic [x_bits-1:0]        x,
    output logic [y_bits-1:0]        y,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     err
);
    localparam int addr_bits = x_bits + y_bits;

    wr_state_t             state, state_n;
    logic [x_bits:0]       width_l;
    logic [y_bits:0]       height_l;
    logic                  transfer, write, err_n, cnt_en, cnt_clr, latch;
    logic                  line_end, last;
    logic [addr_bits-1:0]  addr;

    assign s_ready    = state == WAIT_SOF || state == ACTIVE;
    assign busy       = s_ready;
    assign frame_done = state == DONE;
    assign transfer   = s_valid && s_ready;
    assign addr       = addr_bits'(y) * addr_bits'(width_l) + addr_bits'(x);

    raster_pos_counter #(.x_bits(x_bits), .y_bits(y_bits)) u_pos (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clr),
        .en       (cnt_en),
        .width    (width_l),
        .height   (height_l),
        .x        (x),
        .y        (y),
        .line_end (line_end),
        .last     (last)
    );

    // state, sticky error, latched dimensions and registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            err      <= 1'b0;
            width_l  <= '0;
            height_l <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state <= state_n;
            err   <= err_n;
            wr_en <= write;
            if (latch) begin
                width_l  <= width;
                height_l <= height;
            end
            if (write) begin
                wr_addr <= addr;
                wr_data <= s_data;
            end
        end
    end

    // next state, framing checks and position counter control
    always_comb begin
        state_n = state;
        write   = 1'b0;
        err_n   = err;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        latch   = 1'b0;
        case (state)
            IDLE: begin
                if (start && width != '0 && height != '0) begin
                    latch   = 1'b1;
                    err_n   = 1'b0;
                    cnt_clr = 1'b1;
                    state_n = WAIT_SOF;
                end else if (start) begin
                    err_n = 1'b1;
                end
            end
            WAIT_SOF: begin
                if (transfer && s_sof) begin
                    write   = 1'b1;
                    cnt_en  = 1'b1;
                    state_n = last ? DONE : ACTIVE;
                end
            end
            ACTIVE: begin
                if (transfer && s_sof) begin
                    err_n   = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = WAIT_SOF;
                end else if (transfer) begin
                    write   = 1'b1;
                    cnt_en  = 1'b1;
                    err_n   = err || (s_eol != line_end);
                    state_n = last ? DONE : ACTIVE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
